// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the data-memory arbiter: the FSM state encoding,
// requester port indices and the default address/data widths.
// No ports (package).
// -----------------------------------------------------------------------------
package dm_arb_pkg;

    localparam int AW_DEFAULT = 16;
    localparam int DW_DEFAULT = 32;

    // Requester port indices
    localparam int PORT_CORE = 0;   // processor load/store path
    localparam int PORT_HOST = 1;   // host/debug loader

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_READ   = 2'd2,
        ST_RESP   = 2'd3
    } dm_state_e;

    // Turn a granted port index into its one-hot ACK pattern.
    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_arbiter_if
// Bundles the two requester ports and the single data-memory port.
//
// Handshake: a requester raises REQ[i] with WE[i], ADDRi and WDATAi stable and
// keeps them stable until the arbiter returns a one-cycle ACK[i]. RDATA is
// valid in the ACK cycle of a read. The requester drops REQ[i] in the cycle
// after ACK; a REQ still high when the arbiter is idle is a new request.
//
// Modports:
//   slave  - the arbiter (consumes requests and DM_Q, drives ACK/RDATA/BUSY/DM_*)
//   master - the requester/memory side (drives requests and DM_Q)
// -----------------------------------------------------------------------------
interface dm_arbiter_if #(
    parameter int AW = dm_arb_pkg::AW_DEFAULT,
    parameter int DW = dm_arb_pkg::DW_DEFAULT
);
    logic [1:0]    REQ;
    logic [1:0]    WE;
    logic [AW-1:0] ADDR0;
    logic [AW-1:0] ADDR1;
    logic [DW-1:0] WDATA0;
    logic [DW-1:0] WDATA1;
    logic [1:0]    ACK;
    logic [DW-1:0] RDATA;
    logic          BUSY;
    logic          DM_WE;
    logic [AW-1:0] DM_ADDR;
    logic [DW-1:0] DM_D;
    logic [DW-1:0] DM_Q;

    modport slave (
        input  REQ, WE, ADDR0, ADDR1, WDATA0, WDATA1, DM_Q,
        output ACK, RDATA, BUSY, DM_WE, DM_ADDR, DM_D
    );

    modport master (
        output REQ, WE, ADDR0, ADDR1, WDATA0, WDATA1, DM_Q,
        input  ACK, RDATA, BUSY, DM_WE, DM_ADDR, DM_D
    );
endinterface

// File: rtl/dm_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational 2-way round-robin selector.
// Ports:
//   req_i   [1:0] in   request vector
//   last_i        in   index of the port served most recently
//   win_o         out  winning port index (meaningful when valid_o=1)
//   valid_o       out  at least one request present
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       win_o,
    output logic       valid_o
);
    always_comb begin
        valid_o = |req_i;
        // On a tie the port that was not served last wins; otherwise the
        // single requester wins (req_i[1] is its index when only one is set).
        if (&req_i) begin
            win_o = ~last_i;
        end else begin
            win_o = req_i[1];
        end
    end
endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares one data-memory port between the core load/store path (port 0) and a
// host/debug loader (port 1). Accesses are serialised through the sequence
// IDLE -> ACCESS -> (READ) -> RESP with round-robin fairness on ties.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   bus      slave modport of dm_arbiter_if (requests, ACK/RDATA/BUSY, DM_*)
//   state_o  out  current FSM state (debug observation)
//
// Write: ACCESS at C+1, ACK at C+2. Read: ACCESS at C+1, READ at C+2,
// ACK with RDATA at C+3 (C = cycle in which REQ is sampled in IDLE).
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  bus,
    output dm_state_e    state_o
);

    dm_state_e     state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          dm_we_q, dm_we_d;
    logic [AW-1:0] dm_addr_q, dm_addr_d;
    logic [DW-1:0] dm_d_q, dm_d_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic pick_win;
    logic pick_valid;

    rr_pick2 u_pick (
        .req_i   (bus.REQ),
        .last_i  (last_q),
        .win_o   (pick_win),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        dm_we_d   = 1'b0;          // write enable lives only through ACCESS
        dm_addr_d = dm_addr_q;
        dm_d_d    = dm_d_q;
        rdata_d   = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d     = pick_win;
                    dm_we_d   = bus.WE[pick_win];
                    dm_addr_d = (pick_win == 1'(PORT_CORE)) ? bus.ADDR0  : bus.ADDR1;
                    dm_d_d    = (pick_win == 1'(PORT_CORE)) ? bus.WDATA0 : bus.WDATA1;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // dm_we_q still holds WE of the granted port here.
                state_d = dm_we_q ? ST_RESP : ST_READ;
            end
            ST_READ: begin
                rdata_d = bus.DM_Q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                last_d  = gnt_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A write whose ACCESS cycle coincides with rst still commits: the memory
    // samples dm_we_q on the same edge that clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'(PORT_HOST);
            dm_we_q   <= 1'b0;
            dm_addr_q <= '0;
            dm_d_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            dm_we_q   <= dm_we_d;
            dm_addr_q <= dm_addr_d;
            dm_d_q    <= dm_d_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.ACK     = (state_q == ST_RESP) ? port_onehot(gnt_q) : 2'b00;
    assign bus.BUSY    = (state_q != ST_IDLE);
    assign bus.DM_WE   = dm_we_q;
    assign bus.DM_ADDR = dm_addr_q;
    assign bus.DM_D    = dm_d_q;
    assign bus.RDATA   = rdata_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Self-checking bench for dm_arbiter: reset values, a table of single
// transactions, hand-written multi-cycle corner cases, and a randomized run
// against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic mem_clear;
    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    dm_state_e state_dbg;

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // ---------------- memory model (synchronous read) ----------------
    logic [DW-1:0] mem [256];

    function automatic logic [31:0] init_word(input int i);
        return {8'hA5, 8'(i), 16'(i * 37 + 5)};
    endfunction

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (bus.DM_WE) begin
            mem[bus.DM_ADDR[7:0]] <= bus.DM_D;
        end
        bus.DM_Q <= mem[bus.DM_ADDR[7:0]];
    end

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.REQ = 2'b00; bus.WE = 2'b00;
        bus.ADDR0 = '0; bus.ADDR1 = '0; bus.WDATA0 = '0; bus.WDATA1 = '0;
    endtask

    task automatic drive_port(input logic p, input logic r, input logic w,
                              input logic [15:0] a, input logic [31:0] d);
        bus.REQ[p] = r;
        bus.WE[p]  = w;
        if (p == 1'b0) begin bus.ADDR0 = a; bus.WDATA0 = d; end
        else           begin bus.ADDR1 = a; bus.WDATA1 = d; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        @(negedge clk); mem_clear = 1'b1;
        @(negedge clk); mem_clear = 1'b0;
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [1:0]  exp_ack;
        int          exp_lat;
        logic [31:0] exp_rdata;   // RDATA at ACK (held value for writes)
    } vec_t;

    // One transaction from an idle arbiter; cycle C is the negedge where REQ goes up.
    task automatic run_txn(input vec_t v, input int idx);
        int k, we_count;
        logic [1:0]  ack;
        logic        we_at1;
        logic [15:0] addr_at1;
        logic [31:0] d_at1;
        @(negedge clk);
        check($sformatf("v%0d_busy_idle", idx), bus.BUSY, 1'b0);
        drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        k = 0; we_count = 0; ack = 2'b00;
        we_at1 = 1'b0; addr_at1 = '0; d_at1 = '0;
        while (ack == 2'b00 && k < 8) begin
            @(negedge clk);
            k++;
            if (bus.DM_WE) we_count++;
            if (k == 1) begin
                we_at1 = bus.DM_WE; addr_at1 = bus.DM_ADDR; d_at1 = bus.DM_D;
            end
            ack = bus.ACK;
        end
        check($sformatf("v%0d_latency", idx), 64'(k), 64'(v.exp_lat));
        check($sformatf("v%0d_ack", idx), ack, v.exp_ack);
        check($sformatf("v%0d_rdata", idx), bus.RDATA, v.exp_rdata);
        check($sformatf("v%0d_dm_we_access", idx), we_at1, v.we);
        check($sformatf("v%0d_dm_addr", idx), addr_at1, v.addr);
        check($sformatf("v%0d_dm_we_count", idx), 64'(we_count), v.we ? 64'd1 : 64'd0);
        if (v.we) check($sformatf("v%0d_dm_d", idx), d_at1, v.wdata);
        drive_port(v.port, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    // ---------------- reference model state (random phase) ----------------
    logic [31:0] ref_mem [256];

    initial begin
        vec_t vecs[6];
        vec_t pv;
        logic [1:0] exp_ack;

        rst = 1'b1;
        mem_clear = 1'b0;
        idle_inputs();
        do_reset();
        clear_mem();

        // ---- reset values ----
        @(negedge clk);
        check("rst_ack",     bus.ACK, 2'b00);
        check("rst_busy",    bus.BUSY, 1'b0);
        check("rst_dm_we",   bus.DM_WE, 1'b0);
        check("rst_dm_addr", bus.DM_ADDR, 16'h0);
        check("rst_dm_d",    bus.DM_D, 32'h0);
        check("rst_rdata",   bus.RDATA, 32'h0);
        check("rst_state",   state_dbg, ST_IDLE);

        // ---- table of single transactions ----
        vecs[0] = '{port:1'b0, we:1'b1, addr:16'h0010, wdata:32'hDEADBEEF, exp_ack:2'b01, exp_lat:2, exp_rdata:32'h0};
        vecs[1] = '{port:1'b1, we:1'b0, addr:16'h0010, wdata:32'h0,        exp_ack:2'b10, exp_lat:3, exp_rdata:32'hDEADBEEF};
        vecs[2] = '{port:1'b1, we:1'b1, addr:16'h0044, wdata:32'h12345678, exp_ack:2'b10, exp_lat:2, exp_rdata:32'hDEADBEEF};
        vecs[3] = '{port:1'b0, we:1'b0, addr:16'h0044, wdata:32'h0,        exp_ack:2'b01, exp_lat:3, exp_rdata:32'h12345678};
        vecs[4] = '{port:1'b0, we:1'b0, addr:16'h0003, wdata:32'h0,        exp_ack:2'b01, exp_lat:3, exp_rdata:init_word(3)};
        vecs[5] = '{port:1'b1, we:1'b0, addr:16'h00FF, wdata:32'h0,        exp_ack:2'b10, exp_lat:3, exp_rdata:init_word(255)};
        for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

        // ---- tie and fairness: both ports keep writing from reset ----
        do_reset();
        drive_port(1'b0, 1'b1, 1'b1, 16'h0080, 32'h11110000);
        drive_port(1'b1, 1'b1, 1'b1, 16'h0081, 32'h22220000);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            exp_ack = (k % 3 == 2) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            check($sformatf("tie_ack_c%0d", k), bus.ACK, exp_ack);
        end
        idle_inputs();

        // ---- held request while busy: port 1 read raised during port 0 ACCESS ----
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b1, 16'h0050, 32'h55555555);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) drive_port(1'b1, 1'b1, 1'b0, 16'h0003, 32'h0);
            exp_ack = (k == 2) ? 2'b01 : (k == 6) ? 2'b10 : 2'b00;
            check($sformatf("held_ack_c%0d", k), bus.ACK, exp_ack);
            if (k == 2) drive_port(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
            if (k == 3) check("held_busy_idle", bus.BUSY, 1'b0);
            if (k == 6) begin
                check("held_rdata", bus.RDATA, init_word(3));
                drive_port(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
            end
        end

        // ---- reset mid-read; pointer first primed to port 0 ----
        pv = '{port:1'b0, we:1'b1, addr:16'h0060, wdata:32'h0BADF00D, exp_ack:2'b01, exp_lat:2, exp_rdata:init_word(3)};
        run_txn(pv, 90);
        @(negedge clk);
        drive_port(1'b1, 1'b1, 1'b0, 16'h0044, 32'h0);
        repeat (2) @(negedge clk);
        check("rr_state_read", state_dbg, ST_READ);
        rst = 1'b1;
        drive_port(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("rr_state_idle", state_dbg, ST_IDLE);
        check("rr_ack",   bus.ACK, 2'b00);
        check("rr_rdata", bus.RDATA, 32'h0);
        check("rr_dm_we", bus.DM_WE, 1'b0);
        check("rr_busy",  bus.BUSY, 1'b0);
        drive_port(1'b0, 1'b1, 1'b1, 16'h0070, 32'h70707070);
        drive_port(1'b1, 1'b1, 1'b1, 16'h0071, 32'h71717171);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_ack = (k == 2) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
            check($sformatf("rr_tie_ack_c%0d", k), bus.ACK, exp_ack);
            if (k == 2) drive_port(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
            if (k == 5) drive_port(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        end

        // ---- reset during ACCESS of a write to 0x0020 ----
        @(negedge clk);
        drive_port(1'b1, 1'b1, 1'b1, 16'h0020, 32'hCAFEF00D);
        @(negedge clk);
        check("rw_access_we", bus.DM_WE, 1'b1);
        rst = 1'b1;
        drive_port(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("rw_ack",   bus.ACK, 2'b00);
        check("rw_state", state_dbg, ST_IDLE);
        check("rw_dm_we", bus.DM_WE, 1'b0);
        check("rw_busy",  bus.BUSY, 1'b0);
        @(negedge clk);
        check("rw_ack_after", bus.ACK, 2'b00);
        check("rw_mem_commit", mem[8'h20], 32'hCAFEF00D);

        // ---- randomized run against a transaction-level model ----
        begin
            int m_grant_t, m_ack_t, m_next_idle;
            logic m_gnt, m_we, m_last, win;
            logic [15:0] m_addr;
            logic [31:0] m_wdata, m_rdata_pend, m_rdata_hold;
            int gap[2];
            logic exp_busy, exp_dmwe;

            clear_mem();
            do_reset();
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            m_grant_t = -10; m_ack_t = -10; m_next_idle = 0;
            m_gnt = 1'b0; m_we = 1'b0; m_last = 1'b1;
            m_addr = '0; m_wdata = '0; m_rdata_pend = '0; m_rdata_hold = '0;
            gap[0] = 0; gap[1] = 0;

            for (int t = 0; t < 600; t++) begin
                @(negedge clk);
                exp_ack  = (t == m_ack_t) ? port_onehot(m_gnt) : 2'b00;
                if (t == m_ack_t && !m_we) m_rdata_hold = m_rdata_pend;
                exp_busy = (t > m_grant_t) && (t <= m_ack_t);
                exp_dmwe = (t == m_grant_t + 1) && m_we;
                check($sformatf("rnd_ack_t%0d", t),   bus.ACK, exp_ack);
                check($sformatf("rnd_busy_t%0d", t),  bus.BUSY, exp_busy);
                check($sformatf("rnd_dm_we_t%0d", t), bus.DM_WE, exp_dmwe);
                check($sformatf("rnd_rdata_t%0d", t), bus.RDATA, m_rdata_hold);
                if (exp_dmwe) begin
                    check($sformatf("rnd_dm_addr_t%0d", t), bus.DM_ADDR, m_addr);
                    check($sformatf("rnd_dm_d_t%0d", t),    bus.DM_D, m_wdata);
                end

                // requester behaviour
                for (int p = 0; p < 2; p++) begin
                    if (bus.ACK[p]) begin
                        drive_port(1'(p), 1'b0, 1'b0, 16'h0, 32'h0);
                        gap[p] = $urandom_range(0, 3);
                    end else if (!bus.REQ[p]) begin
                        if (gap[p] > 0) gap[p]--;
                        else if ($urandom_range(0, 1) == 1)
                            drive_port(1'(p), 1'b1, 1'($urandom_range(0, 1)),
                                       16'($urandom_range(0, 15)), $urandom);
                    end
                end

                // model: an idle arbiter serves the request(s) sampled this cycle
                if (t >= m_next_idle && bus.REQ != 2'b00) begin
                    win     = (bus.REQ == 2'b11) ? ~m_last : bus.REQ[1];
                    m_gnt   = win;
                    m_we    = bus.WE[win];
                    m_addr  = win ? bus.ADDR1 : bus.ADDR0;
                    m_wdata = win ? bus.WDATA1 : bus.WDATA0;
                    m_grant_t   = t;
                    m_ack_t     = t + (m_we ? 2 : 3);
                    m_next_idle = m_ack_t + 1;
                    m_last      = win;
                    if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
                    else      m_rdata_pend = ref_mem[m_addr[7:0]];
                end
            end
            idle_inputs();
            repeat (4) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
